// File: rtl/reset_ctrl_pkg.sv
// Shared types for the reset controller: FSM states and reset causes.
// Also provides a counter-width helper used to size the hold/debounce/watchdog counters.
package reset_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HOLD     = 2'b00,
      ST_RUN      = 2'b01,
      ST_DEBOUNCE = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_POR    = 2'b00,
      CAUSE_BUTTON = 2'b01,
      CAUSE_WDT    = 2'b10
   } cause_e;

   function automatic int unsigned cnt_w(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, cleared asynchronously.
// Tie d_i high to use it as a reset synchroniser.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d_i};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/reset_ctrl.sv
// System reset controller: POR hold, debounced button reset, optional watchdog.
// Define RESET_CTRL_WDT_EN to build in the watchdog.
module reset_ctrl #(
   parameter int unsigned HoldCycles       = 1200,
   parameter int unsigned DebounceCycles   = 120000,
   parameter int unsigned WdtTimeoutCycles = 12000000
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       btn_i,
   input  logic       wdt_en_i,
   input  logic       wdt_kick_i,
   output logic       reset_o,
   output logic       ready_o,
   output logic [1:0] reset_cause_o
);
   import reset_ctrl_pkg::*;

   localparam int unsigned HoldW = cnt_w(HoldCycles);
   localparam int unsigned DebW  = cnt_w(DebounceCycles);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);
   localparam logic [DebW-1:0]  DebLast  = DebW'(DebounceCycles - 1);

   logic rst_s_n;
   logic btn_s;

   sync_2ff u_rst_sync (
      .clk_i  (clk_i),
      .rst_ni (reset_ni),
      .d_i    (1'b1),
      .q_o    (rst_s_n)
   );

   sync_2ff u_btn_sync (
      .clk_i  (clk_i),
      .rst_ni (reset_ni),
      .d_i    (btn_i),
      .q_o    (btn_s)
   );

   state_e           state_q, state_d;
   cause_e           cause_q, cause_d;
   logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
   logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
   logic             reset_q, reset_d;
   logic             ready_q, ready_d;
   logic             wdt_fire;

`ifdef RESET_CTRL_WDT_EN
   localparam int unsigned WdtW = cnt_w(WdtTimeoutCycles);
   localparam logic [WdtW-1:0] WdtLast = WdtW'(WdtTimeoutCycles - 1);

   logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;

   // A kick on the expiry cycle wins over the timeout.
   always_comb begin
      wdt_cnt_d = '0;
      wdt_fire  = 1'b0;
      if (state_q != ST_HOLD && wdt_en_i && !wdt_kick_i) begin
         if (wdt_cnt_q == WdtLast) begin
            wdt_fire = 1'b1;
         end else begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_s_n) begin
      if (!rst_s_n) begin
         wdt_cnt_q <= '0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
      end
   end
`else
   logic unused_wdt;
   assign unused_wdt = wdt_en_i ^ wdt_kick_i;
   assign wdt_fire   = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      hold_cnt_d = hold_cnt_q;
      deb_cnt_d  = deb_cnt_q;
      unique case (state_q)
         ST_HOLD: begin
            if (btn_s) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HoldLast) begin
               state_d    = ST_RUN;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (btn_s) begin
               state_d   = ST_DEBOUNCE;
               deb_cnt_d = '0;
            end
         end
         ST_DEBOUNCE: begin
            if (!btn_s) begin
               state_d = ST_RUN;
            end else if (deb_cnt_q == DebLast) begin
               state_d   = ST_HOLD;
               cause_d   = CAUSE_BUTTON;
               deb_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
      if (wdt_fire) begin
         state_d    = ST_HOLD;
         cause_d    = CAUSE_WDT;
         hold_cnt_d = '0;
         deb_cnt_d  = '0;
      end
      reset_d = (state_d == ST_HOLD);
      ready_d = !reset_d;
   end

   always_ff @(posedge clk_i or negedge rst_s_n) begin
      if (!rst_s_n) begin
         state_q    <= ST_HOLD;
         cause_q    <= CAUSE_POR;
         hold_cnt_q <= '0;
         deb_cnt_q  <= '0;
         reset_q    <= 1'b1;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         hold_cnt_q <= hold_cnt_d;
         deb_cnt_q  <= deb_cnt_d;
         reset_q    <= reset_d;
         ready_q    <= ready_d;
      end
   end

   assign reset_o       = reset_q;
   assign ready_o       = ready_q;
   assign reset_cause_o = cause_q;

endmodule

// File: tb/tb_reset_ctrl.sv
// Scoreboard bench for reset_ctrl: the driver queues expected reset_o edges,
// the monitor pops one per observed edge and checks cycle, levels and cause.
module tb_reset_ctrl;

   typedef struct {
      int         cyc;
      logic       rst;
      logic       rdy;
      logic [1:0] cause;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_ni = 1'b1;
   logic       btn_i = 1'b0;
   logic       wdt_en_i = 1'b0;
   logic       wdt_kick_i = 1'b0;
   logic       reset_o;
   logic       ready_o;
   logic [1:0] reset_cause_o;

   int   cyc = 0;
   int   pass = 0;
   int   total = 0;
   exp_t q[$];

   reset_ctrl #(
      .HoldCycles       (8),
      .DebounceCycles   (4),
      .WdtTimeoutCycles (20)
   ) dut (
      .clk_i         (clk),
      .reset_ni      (reset_ni),
      .btn_i         (btn_i),
      .wdt_en_i      (wdt_en_i),
      .wdt_kick_i    (wdt_kick_i),
      .reset_o       (reset_o),
      .ready_o       (ready_o),
      .reset_cause_o (reset_cause_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int req);
      total++;
      if (act == req) pass++;
      else $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
   endfunction

   task automatic expect_edge(int cy, logic r, logic [1:0] ca);
      exp_t e;
      e.cyc   = cy;
      e.rst   = r;
      e.rdy   = !r;
      e.cause = ca;
      q.push_back(e);
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Monitor: every change of reset_o must match the next queued expectation.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'bx;
      forever begin
         @(negedge clk);
         if (reset_o !== prev) begin
            prev = reset_o;
            if (q.size() == 0) begin
               total++;
               $display("FAIL unexpected_edge: reset_o=%b at cyc %0d, required no change", reset_o, cyc);
            end else begin
               e = q.pop_front();
               chk("edge_cycle", cyc, e.cyc);
               chk("reset_o", int'(reset_o), int'(e.rst));
               chk("ready_o", int'(ready_o), int'(e.rdy));
               chk("cause", int'(reset_cause_o), int'(e.cause));
            end
         end
      end
   end

   initial begin
      int c;
      int k;
      // Power-on reset: outputs seen at the first negedge (after edge 1).
      expect_edge(1, 1'b1, 2'b00);
      #1 reset_ni = 1'b0;
      tick(3);
      reset_ni = 1'b1;
      c = cyc;
      expect_edge(c + 10, 1'b0, 2'b00);
      tick(15);

      // Short button glitch: 3 synchronised samples, no reset.
      btn_i = 1'b1;
      tick(3);
      btn_i = 1'b0;
      tick(10);

      // Long press: debounce completes, hold until 8 clocks after btn_s falls.
      c = cyc;
      btn_i = 1'b1;
      expect_edge(c + 7, 1'b1, 2'b01);
      expect_edge(c + 40, 1'b0, 2'b01);
      tick(30);
      btn_i = 1'b0;
      tick(15);

      // reset_ni pulse mid-debounce.
      c = cyc;
      btn_i = 1'b1;
      tick(4);
      reset_ni = 1'b0;
      btn_i = 1'b0;
      expect_edge(c + 4, 1'b1, 2'b00);
      tick(1);
      reset_ni = 1'b1;
      expect_edge(c + 15, 1'b0, 2'b00);
      tick(15);

`ifdef RESET_CTRL_WDT_EN
      // Watchdog timeout with no kicks, then kicks every 15 clocks.
      k = cyc;
      wdt_en_i = 1'b1;
      expect_edge(k + 20, 1'b1, 2'b10);
      expect_edge(k + 28, 1'b0, 2'b10);
      tick(28);
      for (int i = 0; i < 14; i++) begin
         tick(14);
         wdt_kick_i = 1'b1;
         tick(1);
         wdt_kick_i = 1'b0;
      end
      wdt_en_i = 1'b0;
      tick(5);

      // Reset to a button cause first, so the WDT cause below is a fresh update.
      c = cyc;
      btn_i = 1'b1;
      expect_edge(c + 7, 1'b1, 2'b01);
      expect_edge(c + 20, 1'b0, 2'b01);
      tick(10);
      btn_i = 1'b0;
      tick(15);

      // Watchdog expiry on the same edge as debounce completion.
      k = cyc;
      wdt_en_i = 1'b1;
      tick(13);
      c = cyc;
      btn_i = 1'b1;
      expect_edge(k + 20, 1'b1, 2'b10);
      expect_edge(c + 20, 1'b0, 2'b10);
      tick(7);
      wdt_en_i = 1'b0;
      tick(3);
      btn_i = 1'b0;
      tick(15);
`else
      // No watchdog built in: enable without kicks must never reset.
      k = cyc;
      wdt_en_i = 1'b1;
      tick(60);
      wdt_en_i = 1'b0;
      tick(5);
`endif

      tick(5);
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
